mem_responder: RTL and testbench

Memory-side responder for the CPU memory interface. It receives the controller's MAR/MDR load strobes and read/write select, performs the access against an internal RAM after a configurable number of wait states, and returns data and a completion pulse. It sits between the control FSM and datapath on one side and the program/data RAM on the other. It also provides a preload port for loading programs while idle.

---
 rtl/mem_responder_pkg.sv | 27 ++
 rtl/mem_responder_if.sv | 43 ++++
 rtl/mem_responder_array.sv | 25 ++
 rtl/mem_responder.sv | 115 +++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared definitions for the memory responder: access direction codes,
//   FSM state encoding, the wait-state limit and a helper that turns the
//   WAIT_CYCLES parameter into the 4-bit counter load value.
package mem_responder_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Largest wait-state count the 4-bit counter can hold.
  localparam int WAIT_MAX = 15;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_WAIT   = 2'd1,
    MS_ACCESS = 2'd2,
    MS_DONE   = 2'd3
  } ms_state_t;

  // Saturates out-of-range wait counts instead of silently truncating them.
  function automatic logic [3:0] wait_load(input int cycles);
    if (cycles > WAIT_MAX) return 4'(WAIT_MAX);
    else if (cycles < 0)   return 4'd0;
    else                   return 4'(cycles);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Bundle of the controller-facing signals of the memory responder.
//   Names are given from the responder's point of view (i_ = into the
//   responder, o_ = out of it).
//   Handshake: the controller loads MAR with the i_ld_mar level, then raises
//   i_ld_mdr; only the rising edge of i_ld_mdr starts an access, with
//   i_mem_rw sampled on that edge. o_busy is high from the cycle after the
//   edge until the completion cycle, in which o_done pulses for one cycle
//   with o_mdr valid. Strobes issued while o_busy is high are dropped and
//   flagged by a one-cycle o_err pulse on the following cycle.
//   Ports (slave modport): i_addr, i_wdata, i_ld_mar, i_ld_mdr, i_mem_rw,
//   i_prog_we, i_prog_addr, i_prog_data in; o_mdr, o_busy, o_done, o_err out.
interface mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_ld_mar;
  logic              i_ld_mdr;
  logic              i_mem_rw;
  logic              i_prog_we;
  logic [ADDR_W-1:0] i_prog_addr;
  logic [DATA_W-1:0] i_prog_data;
  logic [DATA_W-1:0] o_mdr;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport slave (
    input  i_addr, i_wdata, i_ld_mar, i_ld_mdr, i_mem_rw,
           i_prog_we, i_prog_addr, i_prog_data,
    output o_mdr, o_busy, o_done, o_err
  );

  modport master (
    output i_addr, i_wdata, i_ld_mar, i_ld_mdr, i_mem_rw,
           i_prog_we, i_prog_addr, i_prog_data,
    input  o_mdr, o_busy, o_done, o_err
  );

endinterface

// File: rtl/mem_responder_array.sv
// mem_array
//   Single-port RAM, 2^ADDR_W words of DATA_W bits. Synchronous write on the
//   rising edge of i_clk, asynchronous read of the same address. Contents are
//   never reset.
//   Ports: i_clk, i_we, i_addr, i_wdata in; o_rdata out.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder: captures MAR, starts an access on the rising edge
//   of i_ld_mdr, waits WAIT_CYCLES cycles, performs the read or write against
//   the internal RAM, then pulses o_done with the result held in MDR.
//   A preload port writes the RAM directly while idle.
//   Ports: i_clk, i_rst (synchronous, active-high), bus (mem_responder_if
//   slave modport), o_state (current FSM state, for observation).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mem_responder_if.slave        bus,
  output ms_state_t             o_state
);

  localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  ms_state_t         r_state;
  ms_state_t         w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic [3:0]        w_wait_nxt;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_mdr;
  logic              r_ld_mdr_q;
  logic              r_rw_q;
  logic              r_err;

  logic              w_idle;
  logic              w_access;
  logic              w_start;
  logic              w_collide;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_idle   = (r_state == MS_IDLE);
  assign w_access = (r_state == MS_ACCESS);
  assign w_start  = bus.i_ld_mdr & ~r_ld_mdr_q;

  // Any strobe outside IDLE is dropped and reported one cycle later.
  assign w_collide = ~w_idle & (bus.i_ld_mar | w_start | bus.i_prog_we);

  // Preload owns the RAM port in IDLE, the access path owns it in ACCESS,
  // so the two never compete. Writes are suppressed while reset is held.
  assign w_ram_we    = ~i_rst & ((w_idle & bus.i_prog_we) |
                                 (w_access & (r_rw_q == MEM_WRITE)));
  assign w_ram_addr  = w_access ? r_mar : bus.i_prog_addr;
  assign w_ram_wdata = w_access ? bus.i_wdata : bus.i_prog_data;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      MS_IDLE: begin
        if (w_start) begin
          w_wait_nxt  = WAIT_LOAD;
          w_state_nxt = (WAIT_LOAD != 4'd0) ? MS_WAIT : MS_ACCESS;
        end
      end
      MS_WAIT: begin
        w_wait_nxt = r_wait_cnt - 4'd1;
        // <= 1 also covers a zero count so the FSM can never stall here.
        if (r_wait_cnt <= 4'd1) w_state_nxt = MS_ACCESS;
      end
      MS_ACCESS: w_state_nxt = MS_DONE;
      MS_DONE:   w_state_nxt = MS_IDLE;
      default:   w_state_nxt = MS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= MS_IDLE;
      r_wait_cnt <= 4'd0;
      r_mar      <= '0;
      r_mdr      <= '0;
      r_ld_mdr_q <= 1'b0;
      r_rw_q     <= MEM_READ;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      // Tracked in every state so a level held through DONE cannot retrigger.
      r_ld_mdr_q <= bus.i_ld_mdr;
      r_err      <= w_collide;
      if (w_idle && bus.i_ld_mar) r_mar  <= bus.i_addr;
      if (w_idle && w_start)      r_rw_q <= bus.i_mem_rw;
      if (w_access) r_mdr <= (r_rw_q == MEM_WRITE) ? bus.i_wdata : w_ram_rdata;
    end
  end

  assign bus.o_mdr  = r_mdr;
  assign bus.o_busy = ~w_idle;
  assign bus.o_done = (r_state == MS_DONE);
  assign bus.o_err  = r_err;
  assign o_state    = r_state;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int W1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
  mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  ms_state_t st1;
  ms_state_t st0;

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W1)) dut (
    .i_clk (clk), .i_rst (rst), .bus (bus1), .o_state (st1)
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) dut0 (
    .i_clk (clk), .i_rst (rst), .bus (bus0), .o_state (st0)
  );

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mdl_ram [256];
  logic [AW-1:0] mdl_mar;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus1.i_addr = '0; bus1.i_wdata = '0; bus1.i_ld_mar = 0; bus1.i_ld_mdr = 0;
    bus1.i_mem_rw = 0; bus1.i_prog_we = 0; bus1.i_prog_addr = '0; bus1.i_prog_data = '0;
    bus0.i_addr = '0; bus0.i_wdata = '0; bus0.i_ld_mar = 0; bus0.i_ld_mdr = 0;
    bus0.i_mem_rw = 0; bus0.i_prog_we = 0; bus0.i_prog_addr = '0; bus0.i_prog_data = '0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus1.i_prog_we = 1; bus1.i_prog_addr = a; bus1.i_prog_data = d;
    tick();
    bus1.i_prog_we = 0;
    mdl_ram[a] = d;
  endtask

  // mode 0: load MAR a cycle before the start edge
  // mode 1: load MAR in the same cycle as the start edge
  // mode 2: no MAR load, reuse whatever MAR holds
  // pre: preload RAM[MAR]=pd in the start cycle
  task automatic access(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int mode, input bit pre, input logic [DW-1:0] pd);
    int n;
    if (mode == 0) begin
      bus1.i_ld_mar = 1; bus1.i_addr = a; mdl_mar = a;
      tick();
      bus1.i_ld_mar = 0;
    end else if (mode == 1) begin
      bus1.i_ld_mar = 1; bus1.i_addr = a; mdl_mar = a;
    end
    if (pre) begin
      bus1.i_prog_we = 1; bus1.i_prog_addr = mdl_mar; bus1.i_prog_data = pd;
      mdl_ram[mdl_mar] = pd;
    end
    if (rw == MEM_WRITE) begin
      mdl_ram[mdl_mar] = d;
      exp_q.push_back(d);
    end else begin
      exp_q.push_back(mdl_ram[mdl_mar]);
    end
    bus1.i_ld_mdr = 1; bus1.i_mem_rw = rw; bus1.i_wdata = d;
    tick();
    bus1.i_ld_mdr = 0; bus1.i_ld_mar = 0; bus1.i_prog_we = 0;
    n = 1;
    while (bus1.o_done !== 1'b1 && n < 40) begin
      check("busy_wait", 32'(bus1.o_busy), 1);
      tick();
      n++;
    end
    check("latency", n, W1 + 2);
    check("busy_done", 32'(bus1.o_busy), 1);
    check("mdr", 32'(bus1.o_mdr), 32'(exp_q.pop_front()));
    tick();
    check("busy_after", 32'(bus1.o_busy), 0);
    check("done_after", 32'(bus1.o_done), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n0;
    clear_inputs();
    mdl_mar = '0;
    rst = 1;
    tick(); tick();
    rst = 0;

    // reset state
    check("rst_mdr",   32'(bus1.o_mdr), 0);
    check("rst_busy",  32'(bus1.o_busy), 0);
    check("rst_done",  32'(bus1.o_done), 0);
    check("rst_err",   32'(bus1.o_err), 0);
    check("rst_state", 32'(st1), 32'(MS_IDLE));
    check("rst0_mdr",  32'(bus0.o_mdr), 0);
    check("rst0_busy", 32'(bus0.o_busy), 0);

    // fill the RAM so every later read has a known expected value
    for (int i = 0; i < 256; i++) preload(AW'(i), DW'($urandom_range(0, 255)));

    // preload and read
    preload(8'h05, 8'hA7);
    access(MEM_READ, 8'h05, 8'h00, 0, 0, 8'h00);

    // write then read back
    access(MEM_WRITE, 8'h10, 8'h3C, 0, 0, 8'h00);
    access(MEM_READ, 8'h10, 8'h00, 0, 0, 8'h00);

    // zero wait states on the second instance
    bus0.i_prog_we = 1; bus0.i_prog_addr = 8'hFF; bus0.i_prog_data = 8'h11;
    tick();
    bus0.i_prog_we = 0; bus0.i_ld_mar = 1; bus0.i_addr = 8'hFF;
    tick();
    bus0.i_ld_mar = 0; bus0.i_ld_mdr = 1; bus0.i_mem_rw = MEM_READ;
    tick();
    bus0.i_ld_mdr = 0;
    check("w0_busy", 32'(bus0.o_busy), 1);
    n0 = 1;
    while (bus0.o_done !== 1'b1 && n0 < 20) begin
      tick();
      n0++;
    end
    check("w0_latency", n0, 2);
    check("w0_mdr", 32'(bus0.o_mdr), 32'h11);
    tick();
    check("w0_err", 32'(bus0.o_err), 0);
    check("w0_idle", 32'(bus0.o_busy), 0);

    // held level and busy collisions
    preload(8'h44, 8'h6D);
    bus1.i_ld_mar = 1; bus1.i_addr = 8'h44; mdl_mar = 8'h44;
    tick();
    bus1.i_ld_mar = 0; bus1.i_ld_mdr = 1; bus1.i_mem_rw = MEM_READ;
    tick();
    check("hold_state_wait", 32'(st1), 32'(MS_WAIT));
    bus1.i_ld_mar = 1; bus1.i_addr = 8'h20;
    tick();
    bus1.i_ld_mar = 0;
    check("hold_err_mar", 32'(bus1.o_err), 1);
    bus1.i_prog_we = 1; bus1.i_prog_addr = 8'h44; bus1.i_prog_data = 8'hEE;
    tick();
    bus1.i_prog_we = 0;
    check("hold_done", 32'(bus1.o_done), 1);
    check("hold_err_prog", 32'(bus1.o_err), 1);
    check("hold_mdr", 32'(bus1.o_mdr), 32'h6D);
    tick();
    check("hold_err_clear", 32'(bus1.o_err), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("hold_no_retrigger", 32'(bus1.o_busy), 0);
    end
    bus1.i_ld_mdr = 0;
    tick();
    // MAR still 0x44 and RAM[0x44] untouched by the dropped preload
    access(MEM_READ, 8'h00, 8'h00, 2, 0, 8'h00);

    // simultaneous MAR load and start edge
    preload(8'h07, 8'h5E);
    access(MEM_READ, 8'h07, 8'h00, 1, 0, 8'h00);

    // preload in the start cycle of a read of the same address
    access(MEM_READ, 8'h90, 8'h00, 0, 1, 8'hC4);

    // reset in the middle of a write
    preload(8'h30, 8'h01);
    bus1.i_ld_mar = 1; bus1.i_addr = 8'h30;
    tick();
    bus1.i_ld_mar = 0; bus1.i_ld_mdr = 1; bus1.i_mem_rw = MEM_WRITE; bus1.i_wdata = 8'h99;
    tick();
    bus1.i_ld_mdr = 0;
    check("mid_busy_before", 32'(bus1.o_busy), 1);
    rst = 1;
    tick();
    rst = 0;
    mdl_mar = '0;
    check("mid_busy", 32'(bus1.o_busy), 0);
    check("mid_mdr", 32'(bus1.o_mdr), 0);
    check("mid_state", 32'(st1), 32'(MS_IDLE));
    access(MEM_READ, 8'h00, 8'h00, 2, 0, 8'h00);   // MAR cleared to 0
    access(MEM_READ, 8'h30, 8'h00, 0, 0, 8'h00);   // aborted write left 0x01

    // level high across reset counts as a start on the first cycle after
    bus1.i_ld_mdr = 1; bus1.i_mem_rw = MEM_READ;
    rst = 1;
    tick();
    rst = 0;
    mdl_mar = '0;
    tick();
    check("post_rst_start", 32'(bus1.o_busy), 1);
    bus1.i_ld_mdr = 0;
    n0 = 1;
    while (bus1.o_done !== 1'b1 && n0 < 40) begin
      tick();
      n0++;
    end
    check("post_rst_latency", n0, W1 + 2);
    check("post_rst_mdr", 32'(bus1.o_mdr), 32'(mdl_ram[0]));
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      op = $urandom_range(0, 3);
      ra = AW'($urandom_range(0, 255));
      rd = DW'($urandom_range(0, 255));
      case (op)
        0: preload(ra, rd);
        1: access(MEM_READ, ra, 8'h00, $urandom_range(0, 2), 0, 8'h00);
        2: access(MEM_WRITE, ra, rd, $urandom_range(0, 2), 0, 8'h00);
        default: access(MEM_READ, ra, 8'h00, $urandom_range(0, 1), 1, rd);
      endcase
    end

    check("final_err", 32'(bus1.o_err), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
